// File: rtl/controlador_entrada.sv
// controlador_entrada: debounced button entry of up to three BCD digits for a CPU IN request,
// echoing the digits as they arrive and returning their binary value.
module controlador_entrada #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int NUM_DIGITOS     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_in,
    input  logic        botao,
    input  logic [3:0]  chaves,
    output logic [31:0] dado,
    output logic        pronto,
    output logic        ocupado,
    output logic        erro,
    output logic [3:0]  eco_unidade,
    output logic [3:0]  eco_dezena,
    output logic [3:0]  eco_centena
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

    typedef enum logic [2:0] {
        OCIOSO, ESPERA_APERTO, ESPERA_SOLTA, CONVERTE, PRONTO, ESPERA_BAIXO
    } estado_t;

    estado_t       estado_q, estado_d;
    logic          sync1_q, sync2_q, deb_q, deb_d, deb_ant_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    uni_q, uni_d, dez_q, dez_d, cen_q, cen_d;
    logic [1:0]    qtd_q, qtd_d;
    logic [9:0]    dado_q, dado_d, soma;
    logic          erro_q, erro_d;
    logic          difere, aperto, solta;

    always_comb begin
        difere = sync2_q != deb_q;
        cnt_d  = !difere ? '0 : (cnt_q == CW'(DEBOUNCE_CICLOS) ? cnt_q : cnt_q + CW'(1));
        deb_d  = (difere && cnt_q == CW'(DEBOUNCE_CICLOS - 1)) ? sync2_q : deb_q;
        aperto = deb_q & ~deb_ant_q;
        solta  = ~deb_q & deb_ant_q;
        // digits that were never collected are already zero; masking keeps that explicit
        soma   = (NUM_DIGITOS >= 3 ? 10'(cen_q) * 10'd100 : 10'd0)
               + (NUM_DIGITOS >= 2 ? 10'(dez_q) * 10'd10 : 10'd0)
               + 10'(uni_q);
        ocupado = estado_q == ESPERA_APERTO || estado_q == ESPERA_SOLTA || estado_q == CONVERTE;
        pronto  = estado_q == PRONTO;
    end

    always_comb begin
        estado_d = estado_q;
        uni_d    = uni_q;
        dez_d    = dez_q;
        cen_d    = cen_q;
        qtd_d    = qtd_q;
        dado_d   = dado_q;
        erro_d   = 1'b0;
        // a dropped request wins over any press seen on the same edge
        if (ocupado && !req_in) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO: if (req_in) begin
                    uni_d    = '0;
                    dez_d    = '0;
                    cen_d    = '0;
                    qtd_d    = '0;
                    estado_d = ESPERA_APERTO;
                end
                ESPERA_APERTO: if (aperto) begin
                    if (chaves <= 4'd9) begin
                        cen_d = dez_q;
                        dez_d = uni_q;
                        uni_d = chaves;
                        qtd_d = qtd_q + 2'd1;
                    end else begin
                        erro_d = 1'b1;
                    end
                    estado_d = ESPERA_SOLTA;
                end
                ESPERA_SOLTA: if (solta)
                    estado_d = qtd_q == 2'(NUM_DIGITOS) ? CONVERTE : ESPERA_APERTO;
                CONVERTE: begin
                    dado_d   = soma;
                    estado_d = PRONTO;
                end
                PRONTO:       estado_d = ESPERA_BAIXO;
                ESPERA_BAIXO: estado_d = req_in ? ESPERA_BAIXO : OCIOSO;
                default:      estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_ant_q <= 1'b0;
            cnt_q     <= '0;
            uni_q     <= '0;
            dez_q     <= '0;
            cen_q     <= '0;
            qtd_q     <= '0;
            dado_q    <= '0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            sync1_q   <= botao;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_ant_q <= deb_q;
            cnt_q     <= cnt_d;
            uni_q     <= uni_d;
            dez_q     <= dez_d;
            cen_q     <= cen_d;
            qtd_q     <= qtd_d;
            dado_q    <= dado_d;
            erro_q    <= erro_d;
        end
    end

    assign dado        = {22'd0, dado_q};
    assign erro        = erro_q;
    assign eco_unidade = uni_q;
    assign eco_dezena  = dez_q;
    assign eco_centena = cen_q;
endmodule

// File: tb/tb_controlador_entrada.sv
// tb_controlador_entrada: directed bench for controlador_entrada with a short debounce window.
module tb_controlador_entrada;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_in = 1'b0;
    logic        botao = 1'b0;
    logic [3:0]  chaves = 4'd0;
    logic [31:0] dado;
    logic        pronto, ocupado, erro;
    logic [3:0]  eco_unidade, eco_dezena, eco_centena;
    int tests = 0;
    int fails = 0;
    int prontos = 0;
    int erros = 0;
    int n;
    logic ocup_ant;

    controlador_entrada #(.DEBOUNCE_CICLOS(4), .NUM_DIGITOS(3)) dut (
        .clock(clock), .reset(reset), .req_in(req_in), .botao(botao), .chaves(chaves),
        .dado(dado), .pronto(pronto), .ocupado(ocupado), .erro(erro),
        .eco_unidade(eco_unidade), .eco_dezena(eco_dezena), .eco_centena(eco_centena)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pronto) prontos <= prontos + 1;
        if (erro) erros <= erros + 1;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] v);
        chaves = v;
        botao = 1'b1;
        repeat (10) step();
        botao = 1'b0;
        repeat (10) step();
    endtask

    task automatic novo_pedido;
        req_in = 1'b0;
        step();
        req_in = 1'b1;
        step();
    endtask

    initial begin
        #2;
        chk("reset_dado", dado, 0);
        chk("reset_sinais", {28'd0, pronto, ocupado, erro}, 0);
        chk("reset_eco", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        step();
        reset = 1'b1;
        step();
        press(4'd5);
        chk("ocioso_ignora", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        chk("ocioso_livre", {31'd0, ocupado}, 0);
        req_in = 1'b1;
        step();
        chk("aceita_ocupado", {31'd0, ocupado}, 1);
        press(4'd1);
        press(4'd2);
        chk("eco_dois", {24'd0, eco_dezena, eco_unidade}, 8'h12);
        chaves = 4'd3;
        botao = 1'b1;
        repeat (10) step();
        botao = 1'b0;
        n = 0;
        ocup_ant = 1'b0;
        while (!pronto && n < 20) begin
            ocup_ant = ocupado;
            step();
            n++;
        end
        chk("latencia_pronto", n, 8);
        chk("ocupado_cai", {30'd0, ocup_ant, ocupado}, 2'b10);
        chk("dado_123", dado, 123);
        chk("eco_123", {20'd0, eco_centena, eco_dezena, eco_unidade}, 12'h123);
        step();
        chk("pronto_pulso", {31'd0, pronto}, 0);
        press(4'd5);
        repeat (5) step();
        chk("sem_segundo_pronto", prontos, 1);
        chk("baixo_mantem", dado, 123);
        chk("baixo_livre", {31'd0, ocupado}, 0);
        novo_pedido();
        chk("novo_ocupado", {31'd0, ocupado}, 1);
        chk("novo_eco", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        chaves = 4'd9;
        for (int i = 0; i < 3; i++) begin
            botao = 1'b1;
            repeat (3) step();
            botao = 1'b0;
            repeat (3) step();
        end
        repeat (10) step();
        chk("glitch_sem_digito", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        press(4'd7);
        chk("glitch_um_digito", {20'd0, eco_centena, eco_dezena, eco_unidade}, 12'h007);
        press(4'd12);
        chk("erro_pulso", erros, 1);
        chk("erro_eco", {20'd0, eco_centena, eco_dezena, eco_unidade}, 12'h007);
        press(4'd8);
        press(4'd9);
        chk("dado_789", dado, 789);
        chk("prontos_2", prontos, 2);
        novo_pedido();
        press(4'd12);
        press(4'd0);
        press(4'd4);
        chk("erro_sem_conta", {31'd0, ocupado}, 1);
        press(4'd5);
        chk("dado_45", dado, 45);
        chk("erros_2", erros, 2);
        chk("prontos_3", prontos, 3);
        novo_pedido();
        press(4'd6);
        press(4'd7);
        chaves = 4'd3;
        botao = 1'b1;
        repeat (6) step();
        req_in = 1'b0;
        step();
        chk("aborto_livre", {31'd0, ocupado}, 0);
        chk("aborto_prioridade", {24'd0, eco_dezena, eco_unidade}, 8'h67);
        botao = 1'b0;
        repeat (10) step();
        chk("aborto_sem_pronto", prontos, 3);
        chk("aborto_dado", dado, 45);
        req_in = 1'b1;
        step();
        chk("aborto_novo_eco", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        press(4'd1);
        botao = 1'b1;
        repeat (10) step();
        #2;
        reset = 1'b0;
        req_in = 1'b0;
        #1;
        chk("reset_async_sinais", {28'd0, pronto, ocupado, erro}, 0);
        chk("reset_async_dado", dado, 0);
        chk("reset_async_eco", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (12) step();
        req_in = 1'b1;
        step();
        repeat (10) step();
        chk("segurado_ignorado", {20'd0, eco_centena, eco_dezena, eco_unidade}, 0);
        botao = 1'b0;
        repeat (10) step();
        press(4'd5);
        chk("reaperto_conta", {20'd0, eco_centena, eco_dezena, eco_unidade}, 12'h005);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controlador_entrada.md
CONTROLADOR_ENTRADA -- requirements
Module: controlador_entrada

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 50000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter NUM_DIGITOS, default 3, meaning decimal digits collected per request (legal 1..3).
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_in  input  1  level request from the CPU, held high while an IN instruction waits.
REQ-006 SHALL have port botao  input  1  raw, asynchronous, bouncing board button; pressed = 1.
REQ-007 SHALL have port chaves  input  4  raw switch value, one BCD digit.
REQ-008 SHALL have port dado  output  32  binary value of the collected digits, zero-extended.
REQ-009 SHALL have port pronto  output  1  one-cycle pulse: dado is valid.
REQ-010 SHALL have port ocupado  output  1  high from request acceptance until pronto or abort.
REQ-011 SHALL have port erro  output  1  one-cycle pulse: the press carried a digit greater than 9.
REQ-012 SHALL have ports eco_unidade, eco_dezena, eco_centena  output  4 each  digits entered so far, for display echo.

Function
REQ-013 SHALL pass botao through a 2-flop synchronizer before any other use.
REQ-014 SHALL update the debounced level only after the synchronized input differs from it for DEBOUNCE_CICLOS consecutive cycles; any return to equality clears the counter.
REQ-015 SHALL define a press event as a 0->1 change of the debounced level and a release event as a 1->0 change.
REQ-016 SHALL implement the states OCIOSO, ESPERA_APERTO, ESPERA_SOLTA, CONVERTE, PRONTO and ESPERA_BAIXO.
REQ-017 OCIOSO: when req_in=1, SHALL clear the eco digits and the digit count, then go to ESPERA_APERTO; press events in OCIOSO SHALL be ignored.
REQ-018 ESPERA_APERTO: on a press event with chaves<=9, SHALL shift the eco digits up (centena<=dezena, dezena<=unidade, unidade<=chaves), increment the count, then go to ESPERA_SOLTA.
REQ-019 ESPERA_APERTO: on a press event with chaves>9, SHALL pulse erro for one cycle, leave the digits and count unchanged, then go to ESPERA_SOLTA.
REQ-020 ESPERA_SOLTA: on a release event, SHALL go to CONVERTE if count=NUM_DIGITOS, else back to ESPERA_APERTO.
REQ-021 CONVERTE: SHALL register dado = centena*100 + dezena*10 + unidade, with digits beyond NUM_DIGITOS contributing zero; SHALL then go to PRONTO.
REQ-022 PRONTO: SHALL hold pronto=1 for exactly this one cycle, deassert ocupado, then go to ESPERA_BAIXO.
REQ-023 ESPERA_BAIXO: SHALL stay until req_in=0, then go to OCIOSO, so that a held request never yields a second pronto.
REQ-024 pronto SHALL rise on the 2nd rising clock edge after the edge on which the final release event is registered.
REQ-025 SHALL compute ocupado = 1 in ESPERA_APERTO, ESPERA_SOLTA and CONVERTE, and 0 otherwise.
REQ-026 If req_in falls in ESPERA_APERTO, ESPERA_SOLTA or CONVERTE, SHALL abort to OCIOSO on the next edge, with no pronto and dado unchanged.
REQ-027 If req_in falls on the same edge as a press event, the abort SHALL take priority and the digit SHALL NOT be stored.
REQ-028 dado SHALL hold its last value until the next CONVERTE; maximum value 999, no overflow possible.
REQ-029 The debounce counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-030 On reset=0 SHALL set, asynchronously: state OCIOSO, dado=0, pronto=0, ocupado=0, erro=0, eco digits=0, count=0, synchronizer and debounced level=0, debounce counter=0.
REQ-031 Reset mid-operation SHALL discard partial digits; after reset release, a held botao SHALL be seen as a press only after it debounces high from the 0 level.

Verification (DEBOUNCE_CICLOS=4, NUM_DIGITOS=3)
REQ-032 req_in=1, then three clean presses with chaves 1, 2, 3 -> eco shows 1/2/3; pronto pulses once; dado=123; ocupado falls with pronto.
REQ-033 Press glitches of 3 cycles or shorter, then a 10-cycle press with chaves=7 -> only one digit is counted (7); no extra digits.
REQ-034 Press with chaves=12 -> erro pulses once and the count stays unchanged; subsequent presses 0, 4, 5 -> dado=45.
REQ-035 req_in dropped after two digits -> state returns to OCIOSO with no pronto; dado keeps its previous value; a new request starts with eco=0.
REQ-036 req_in held high after pronto -> no second pronto while further presses occur; lowering and re-raising req_in starts a new collection.
REQ-037 reset asserted during ESPERA_SOLTA with botao held -> all outputs 0 immediately; after release, botao must go low and then high again before a press is counted.
